instr_fetch_reg: RTL
====================

# instr_fetch_reg

- Multicycle-datapath instruction register with a fetch handshake to instruction memory.
- On a fetch request from the control FSM it issues a memory read, waits for acknowledge with a bounded timeout, and latches the 16-bit instruction.
- It decodes the latched instruction into opcode, register and 8-bit immediate fields.
- The `imm8` output feeds the downstream sign extender, which widens it to 16 bits.

## Interface
Parameters:
- `DATA_W`, 16, instruction width; fields below assume 16
- `TIMEOUT_CYC`, 15, max cycles in REQ without `mem_ack` before error (1..255)

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `fetch_start`  in  1  control FSM request for a new instruction (IRWrite phase)
- `flush`  in  1  synchronous abort/clear
- `mem_req`  out  1  read request to instruction memory
- `mem_ack`  in  1  memory data valid, sampled only while `mem_req`=1
- `mem_rdata`  in  DATA_W  instruction word from memory
- `instr`  out  DATA_W  latched instruction register
- `opcode`  out  4  `instr[15:12]`
- `rd`  out  2  `instr[11:10]`
- `rs`  out  2  `instr[9:8]`
- `imm8`  out  8  `instr[7:0]`, to sign extender
- `ir_valid`  out  1  IR holds a fresh, accepted instruction
- `busy`  out  1  high in REQ
- `timeout_err`  out  1  high in ERR

## Operation
- States: IDLE, REQ, ERR. Encoding is free; all outputs are registered or decoded from state.
- IDLE:
  - `fetch_start`=1 → REQ; timeout counter cleared; `ir_valid` cleared.
- REQ:
  - `mem_req`=1 and `busy`=1.
  - `mem_ack`=1 → `instr`<=`mem_rdata`, `ir_valid`<=1, → IDLE.
  - Otherwise counter += 1; when counter reaches `TIMEOUT_CYC`-1 without ack → ERR.
- ERR:
  - `mem_req`=0, `timeout_err`=1; `instr` unchanged; `ir_valid`=0.
  - `fetch_start` → REQ (counter cleared); `flush` → IDLE.
- Field outputs are pure wiring of `instr`, so they are always consistent with it.
- `fetch_start` in REQ is ignored; there is no queuing.
- `flush` (any state) → IDLE, `ir_valid`=0, `instr`=0. `flush` wins over a simultaneous `mem_ack` (data discarded) and over `fetch_start`.
- `mem_ack` outside REQ is ignored.
- The counter is 8 bits and saturates; it never wraps.

## Timing
- Reset (async assert, sync deassert in the system): state IDLE, `instr`=0, all field outputs 0, `mem_req`=0, `busy`=0, `ir_valid`=0, `timeout_err`=0, counter 0.
- Reset asserted mid-REQ:
  - `mem_req` drops immediately, without waiting for a clock edge.
  - An in-flight ack is lost.
- Latency:
  - `fetch_start` high at edge 0 → `mem_req` high after edge 0.
  - `mem_ack` high at edge k → `instr` and `ir_valid` valid after edge k; `mem_req` low after edge k.
  - Minimum: ack at edge 1 gives a 2-edge fetch.
- Timeout: with no ack, `mem_req` is high for exactly `TIMEOUT_CYC` cycles; `timeout_err` rises after edge `TIMEOUT_CYC`.
- Ack on the final timeout cycle is accepted; ack takes priority over timeout.
- Back-to-back:
  - `fetch_start` may be asserted in the cycle `ir_valid` first reads 1.
  - `ir_valid` drops after that edge; `instr` keeps the old value until the next ack.

## Configuration
- `IR_PARITY_EN` defined:
  - Adds input `mem_rparity` (1 bit, even parity over `mem_rdata`) and output `parity_err`.
  - On accepted ack, `instr` latches the word regardless of parity.
  - If `^mem_rdata ^ mem_rparity`=1 → `ir_valid` stays 0, `parity_err`=1, → ERR.
  - `timeout_err` stays 0 on a parity failure.
  - `parity_err` clears on `fetch_start`, `flush` or reset.
- `IR_PARITY_EN` undefined:
  - Neither port exists.
  - Every ack in REQ is accepted.

## Test plan
- Reset then basic fetch: `fetch_start` pulse, ack 3 cycles later with `mem_rdata`=16'h5AF3 → `ir_valid`=1, `opcode`=4'h5, `rd`=2'b10, `rs`=2'b10, `imm8`=8'hF3; `mem_req` high exactly 3 cycles.
- Minimum latency: ack in the first REQ cycle with 16'h124F → `imm8`=8'h4F one edge later; back-to-back `fetch_start` in the same cycle starts a new REQ, `instr` holds 16'h124F.
- Timeout: `TIMEOUT_CYC`=4, no ack → `mem_req` high 4 cycles, then `timeout_err`=1, `instr` unchanged; a later `fetch_start` clears `timeout_err`, and ack with 16'h0001 → `ir_valid`=1.
- Ack on the last timeout cycle: ack with 16'h8080 at cycle 4 of 4 → accepted, no error.
- Flush collision: `flush` and `mem_ack` (16'hFFFF) in the same cycle → IDLE, `instr`=0, `ir_valid`=0; async `rst_n` low mid-REQ → `mem_req`=0 immediately.
- `IR_PARITY_EN` defined: 16'h0003 with `mem_rparity`=1 → `parity_err`=1, `ir_valid`=0; the same word with parity 0 → `ir_valid`=1.

Source files
------------

// File: rtl/instr_fetch_reg.sv
// instr_fetch_reg: multicycle-datapath instruction register.
// Issues a read to instruction memory when the control FSM requests a fetch,
// waits for acknowledge under a bounded timeout, latches the 16-bit word and
// decodes it into opcode / rd / rs / imm8 fields.
// Optional feature: define IR_PARITY_EN to add even-parity checking of the
// fetched word (input mem_rparity, output parity_err).
module instr_fetch_reg #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_start,
  input  logic              flush,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef IR_PARITY_EN
  input  logic              mem_rparity,
  output logic              parity_err,
`endif
  output logic [DATA_W-1:0] instr,
  output logic [3:0]        opcode,
  output logic [1:0]        rd,
  output logic [1:0]        rs,
  output logic [7:0]        imm8,
  output logic              ir_valid,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  // Counter value seen on the last REQ cycle; reaching it without ack times out.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              ir_valid_q, ir_valid_d;
  logic              par_bad;
  logic              par_err_q, par_err_d;

`ifdef IR_PARITY_EN
  assign par_bad = (^mem_rdata) ^ mem_rparity;
`else
  assign par_bad = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      instr_q    <= '0;
      ir_valid_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      instr_q    <= instr_d;
      ir_valid_q <= ir_valid_d;
      par_err_q  <= par_err_d;
    end
  end

  // Next-state and next-register values; flush overrides everything.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    instr_d    = instr_q;
    ir_valid_d = ir_valid_q;
    par_err_d  = par_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (fetch_start) begin
          state_d    = S_REQ;
          cnt_d      = '0;
          ir_valid_d = 1'b0;
          par_err_d  = 1'b0;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          // The word is latched even when parity fails.
          instr_d = mem_rdata;
          if (par_bad) begin
            par_err_d = 1'b1;
            state_d   = S_ERR;
          end else begin
            ir_valid_d = 1'b1;
            state_d    = S_IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_ERR: begin
        ir_valid_d = 1'b0;
        if (fetch_start) begin
          state_d   = S_REQ;
          cnt_d     = '0;
          par_err_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (flush) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      instr_d    = '0;
      ir_valid_d = 1'b0;
      par_err_d  = 1'b0;
    end
  end

  assign mem_req     = (state_q == S_REQ);
  assign busy        = (state_q == S_REQ);
  assign timeout_err = (state_q == S_ERR) && !par_err_q;
  assign ir_valid    = ir_valid_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[15:12];
  assign rd          = instr_q[11:10];
  assign rs          = instr_q[9:8];
  assign imm8        = instr_q[7:0];

`ifdef IR_PARITY_EN
  assign parity_err = par_err_q;
`endif

endmodule
